read_resp_return: RTL

//  Consumer end of the outstanding-read request-ID FIFO. Pairs each backend read-data beat with
//  the oldest outstanding req_id, popping that FIFO in the same cycle.

---
 rtl/read_resp_return_if.sv | 36 +++
 rtl/read_resp_return.sv | 115 +++++++++++
 2 files changed

// File: rtl/read_resp_return_if.sv
// Read-response return bundle: backend beat, ID FIFO head/pop, frontend response, status and sticky errors.
// Latency: n/a (signal grouping only).
// Backpressure: frontend ready is the only stall; the backend beat path has no ready.
interface read_resp_return_if #(
    parameter int ID_WIDTH       = 5,
    parameter int DATA_WIDTH     = 64,
    parameter int BUF_DEPTH_LOG2 = 2
);
    logic                      i_rdata_valid;
    logic [DATA_WIDTH-1:0]     i_rdata;
    logic [ID_WIDTH-1:0]       i_id_data;
    logic                      i_id_empty;
    logic                      o_id_rd_en;
    logic                      o_resp_valid;
    logic                      i_resp_ready;
    logic [ID_WIDTH-1:0]       o_resp_id;
    logic [DATA_WIDTH-1:0]     o_resp_data;
    logic [BUF_DEPTH_LOG2:0]   o_buf_count;
    logic                      o_buf_full;
    logic                      i_err_clr;
    logic                      o_err_overflow;
    logic                      o_err_orphan;
    logic                      o_err_timeout;

    modport slave (
        input  i_rdata_valid, i_rdata, i_id_data, i_id_empty, i_resp_ready, i_err_clr,
        output o_id_rd_en, o_resp_valid, o_resp_id, o_resp_data, o_buf_count, o_buf_full,
               o_err_overflow, o_err_orphan, o_err_timeout
    );

    modport master (
        output i_rdata_valid, i_rdata, i_id_data, i_id_empty, i_resp_ready, i_err_clr,
        input  o_id_rd_en, o_resp_valid, o_resp_id, o_resp_data, o_buf_count, o_buf_full,
               o_err_overflow, o_err_orphan, o_err_timeout
    );
endinterface

// File: rtl/read_resp_return.sv
// Pairs backend read beats with the oldest ID FIFO entry and queues {id, data}; READ_RESP_TIMEOUT_EN adds a watchdog.
// Latency: 1 cycle from beat to o_resp_valid on an empty queue.
// Backpressure: i_resp_ready stalls the queue; the backend cannot stall, so beats are dropped when full.
module read_resp_return #(
    parameter int ID_WIDTH       = 5,
    parameter int DATA_WIDTH     = 64,
    parameter int BUF_DEPTH_LOG2 = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             i_clk,
    input  logic             i_rst,
    read_resp_return_if.slave bus
);
    localparam int DEPTH = 1 << BUF_DEPTH_LOG2;
    localparam int PW    = BUF_DEPTH_LOG2 + 1;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] dat;
    } resp_t;

    resp_t           mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   count;
    logic            full;
    logic            resp_vld;
    logic            pop;
    logic            id_pop;
    logic            push;
    logic            ovf_evt;
    logic            orph_evt;
    logic            err_ovf;
    logic            err_orph;
    resp_t           head;

    assign count    = wr_ptr - rd_ptr;
    assign full     = (count == PW'(DEPTH));
    assign resp_vld = (count != '0);
    assign pop      = resp_vld && bus.i_resp_ready;
    // The ID is consumed even when the beat is dropped so IDs stay aligned with data.
    assign id_pop   = bus.i_rdata_valid && !bus.i_id_empty;
    assign push     = id_pop && (!full || pop);
    assign ovf_evt  = id_pop && full && !pop;
    assign orph_evt = bus.i_rdata_valid && bus.i_id_empty;
    assign head     = mem[rd_ptr[BUF_DEPTH_LOG2-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr[BUF_DEPTH_LOG2-1:0]] <= '{id: bus.i_id_data, dat: bus.i_rdata};
    end

    // Sticky flags: a coincident set event beats the clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_ovf  <= 1'b0;
            err_orph <= 1'b0;
        end else begin
            if (ovf_evt)            err_ovf <= 1'b1;
            else if (bus.i_err_clr) err_ovf <= 1'b0;
            if (orph_evt)           err_orph <= 1'b1;
            else if (bus.i_err_clr) err_orph <= 1'b0;
        end
    end

    assign bus.o_id_rd_en     = id_pop;
    assign bus.o_resp_valid   = resp_vld;
    assign bus.o_resp_id      = resp_vld ? head.id  : '0;
    assign bus.o_resp_data    = resp_vld ? head.dat : '0;
    assign bus.o_buf_count    = count;
    assign bus.o_buf_full     = full;
    assign bus.o_err_overflow = err_ovf;
    assign bus.o_err_orphan   = err_orph;

`ifdef READ_RESP_TIMEOUT_EN
    localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] tmo_cnt;
    logic          tmo_inc;
    logic          tmo_hit;
    logic          err_tmo;

    // Counts only while an ID is outstanding and no beat shows up.
    assign tmo_inc = !bus.i_id_empty && !bus.i_rdata_valid;
    assign tmo_hit = tmo_inc && (tmo_cnt >= TMO_MAX - TW'(1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tmo_cnt <= '0;
            err_tmo <= 1'b0;
        end else begin
            if (!tmo_inc)               tmo_cnt <= '0;
            else if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + TW'(1);
            if (tmo_hit)                err_tmo <= 1'b1;
            else if (bus.i_err_clr)     err_tmo <= 1'b0;
        end
    end

    assign bus.o_err_timeout = err_tmo;
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg    = ^TIMEOUT_CYCLES;
    assign bus.o_err_timeout = 1'b0;
`endif
endmodule
